// File: rtl/wb_dcache_victim_ctrl_pkg.sv
// Shared definitions for the write-back dcache / victim cache controller:
// FSM state encoding, default geometry and the perf event bundle.
package wb_dcache_victim_ctrl_pkg;

  localparam int unsigned DCACHE_IDX_BITS = 5;
  localparam int unsigned DCACHE_SETS     = 1 << DCACHE_IDX_BITS;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PROBE,
    S_WRITE,
    S_WRBACK,
    S_VSWAP,
    S_ALLOC_PUSH,
    S_ALLOC_RD,
    S_FLUSH_RD,
    S_FLUSH_CHK,
    S_FLUSH_WB,
    S_FLUSH_DONE
  } type_dcache_ctrl_state_e;

  typedef struct packed {
    logic hit;
    logic miss;
    logic victim_hit;
    logic wrback;
  } dcache_perf_evt_t;

endpackage

// File: rtl/wb_dcache_victim_ctrl_flush_walker.sv
// Flush set-index walker: index register with clear/increment from the
// controller FSM and a last-set flag.
module dcache_flush_walker
  import wb_dcache_victim_ctrl_pkg::*;
#(
  parameter int unsigned IDX_BITS = DCACHE_IDX_BITS,
  parameter int unsigned SETS     = DCACHE_SETS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                last_o
);

  logic [IDX_BITS-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_BITS'(SETS - 1));

endmodule

// File: rtl/wb_dcache_victim_ctrl.sv
// Write-back dcache + victim cache controller FSM (probe, swap, write-back,
// allocate, flush). Optional perf counters under `DCACHE_PERF_CNT_EN.
module wb_dcache_victim_ctrl #(
  parameter int unsigned DCACHE_IDX_BITS = wb_dcache_victim_ctrl_pkg::DCACHE_IDX_BITS,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsummu2dcache_req_i,
  input  logic                       lsummu2dcache_wr_i,
  output logic                       dcache2lsummu_ack_o,
  input  logic                       dcache_flush_i,
  output logic                       dcache_flush_ack_o,
  input  logic                       cache_hit_i,
  input  logic                       cache_evict_req_i,
  input  logic                       dcache_valid_i,
  input  logic                       victim_hit_i,
  output logic                       cache_wr_o,
  output logic                       cache_line_wr_o,
  output logic                       cache_line_clean_o,
  output logic                       cache_wrb_req_o,
  output logic [DCACHE_IDX_BITS-1:0] evict_index_o,
  output logic                       write_to_victim_o,
  output logic                       write_from_victim_o,
  output logic                       lsu_victim_mux_sel_o,
  output logic                       dcache2mem_req_o,
  output logic                       dcache2mem_wr_o,
  input  logic                       mem2dcache_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]       hit_cnt_o,
  output logic [CNT_WIDTH-1:0]       miss_cnt_o,
  output logic [CNT_WIDTH-1:0]       victim_hit_cnt_o,
  output logic [CNT_WIDTH-1:0]       wrback_cnt_o
`endif
);

  import wb_dcache_victim_ctrl_pkg::*;

  if (CNT_WIDTH == 0) begin : g_cnt_width_chk
    $error("CNT_WIDTH must be nonzero");
  end

  type_dcache_ctrl_state_e state_q, state_d;
  logic victim_q, victim_d;
  logic walk_inc, walk_clr, walk_last;

  dcache_flush_walker #(
    .IDX_BITS (DCACHE_IDX_BITS),
    .SETS     (2 ** DCACHE_IDX_BITS)
  ) u_walker (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (walk_inc),
    .clr_i  (walk_clr),
    .idx_o  (evict_index_o),
    .last_o (walk_last)
  );

  always_comb begin
    state_d              = state_q;
    victim_d             = victim_q;
    walk_inc             = 1'b0;
    walk_clr             = 1'b0;
    dcache2lsummu_ack_o  = 1'b0;
    dcache_flush_ack_o   = 1'b0;
    cache_wr_o           = 1'b0;
    cache_line_wr_o      = 1'b0;
    cache_line_clean_o   = 1'b0;
    cache_wrb_req_o      = 1'b0;
    write_to_victim_o    = 1'b0;
    write_from_victim_o  = 1'b0;
    lsu_victim_mux_sel_o = 1'b0;
    dcache2mem_req_o     = 1'b0;
    dcache2mem_wr_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dcache_flush_i)           state_d = S_FLUSH_RD;
        else if (lsummu2dcache_req_i) state_d = S_PROBE;
      end
      S_PROBE: begin
        if (cache_hit_i) begin
          if (lsummu2dcache_wr_i) state_d = S_WRITE;
          else begin
            dcache2lsummu_ack_o = 1'b1;
            state_d             = S_IDLE;
          end
        end else begin
          victim_d = victim_hit_i;
          if (cache_evict_req_i) state_d = S_WRBACK;
          else if (victim_hit_i) state_d = S_VSWAP;
          else                   state_d = S_ALLOC_PUSH;
        end
      end
      S_WRITE: begin
        cache_wr_o          = 1'b1;
        dcache2lsummu_ack_o = 1'b1;
        state_d             = S_IDLE;
      end
      S_WRBACK: begin
        dcache2mem_req_o = 1'b1;
        dcache2mem_wr_o  = 1'b1;
        cache_wrb_req_o  = 1'b1;
        if (mem2dcache_ack_i) begin
          cache_line_clean_o = 1'b1;
          state_d            = victim_q ? S_VSWAP : S_ALLOC_PUSH;
        end
      end
      S_VSWAP: begin
        write_to_victim_o   = dcache_valid_i;
        write_from_victim_o = 1'b1;
        if (lsummu2dcache_wr_i) state_d = S_PROBE;
        else begin
          lsu_victim_mux_sel_o = 1'b1;
          dcache2lsummu_ack_o  = 1'b1;
          state_d              = S_IDLE;
        end
      end
      S_ALLOC_PUSH: begin
        write_to_victim_o = dcache_valid_i;
        state_d           = S_ALLOC_RD;
      end
      S_ALLOC_RD: begin
        dcache2mem_req_o = 1'b1;
        if (mem2dcache_ack_i) begin
          cache_line_wr_o = 1'b1;
          state_d         = S_PROBE;
        end
      end
      S_FLUSH_RD: state_d = S_FLUSH_CHK;
      S_FLUSH_CHK: begin
        if (cache_evict_req_i) state_d = S_FLUSH_WB;
        else begin
          walk_inc = !walk_last;
          state_d  = walk_last ? S_FLUSH_DONE : S_FLUSH_RD;
        end
      end
      S_FLUSH_WB: begin
        dcache2mem_req_o = 1'b1;
        dcache2mem_wr_o  = 1'b1;
        cache_wrb_req_o  = 1'b1;
        if (mem2dcache_ack_i) begin
          cache_line_clean_o = 1'b1;
          walk_inc           = !walk_last;
          state_d            = walk_last ? S_FLUSH_DONE : S_FLUSH_RD;
        end
      end
      S_FLUSH_DONE: begin
        dcache_flush_ack_o = 1'b1;
        walk_clr           = 1'b1;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  dcache_perf_evt_t          evt;
  logic [3:0]                evt_v;
  logic                      reprobe_q;
  logic [CNT_WIDTH-1:0]      cnt_q [4];

  // A PROBE entered from anywhere but IDLE is a re-probe after fill/swap.
  always_comb begin
    evt            = '0;
    evt.hit        = (state_q == S_PROBE) && !reprobe_q && cache_hit_i;
    evt.miss       = (state_q == S_PROBE) && !reprobe_q && !cache_hit_i;
    evt.victim_hit = evt.miss && victim_hit_i;
    evt.wrback     = ((state_q == S_WRBACK) || (state_q == S_FLUSH_WB)) && mem2dcache_ack_i;
  end
  assign evt_v = evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) reprobe_q <= 1'b0;
    else     reprobe_q <= (state_d == S_PROBE) && (state_q != S_IDLE);
  end

  for (genvar g = 0; g < 4; g++) begin : g_perf_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                         cnt_q[g] <= '0;
      else if (evt_v[g] && !(&cnt_q[g])) cnt_q[g] <= cnt_q[g] + 1'b1;
    end
  end

  assign hit_cnt_o        = cnt_q[3];
  assign miss_cnt_o       = cnt_q[2];
  assign victim_hit_cnt_o = cnt_q[1];
  assign wrback_cnt_o     = cnt_q[0];
`endif

  logic lsu_busy;
  assign lsu_busy = (state_q == S_PROBE) || (state_q == S_WRITE) || (state_q == S_WRBACK) ||
                    (state_q == S_VSWAP) || (state_q == S_ALLOC_PUSH) || (state_q == S_ALLOC_RD);

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    lsu_busy |-> lsummu2dcache_req_i);

  a_one_ram_write: assert property (@(posedge clk) disable iff (rst)
    $onehot0({cache_wr_o, cache_line_wr_o, write_from_victim_o}));

endmodule

// File: tb/tb_wb_dcache_victim_ctrl.sv
// Directed bench for wb_dcache_victim_ctrl: transaction-level model expands each
// scenario into per-cycle stimulus/expected-output queues, checked every cycle.
module tb_wb_dcache_victim_ctrl;
  localparam int unsigned IDX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req, wr, ack, flush, fack, hit, evict, valid, vhit;
  logic cwr, lwr, clean, wrb, wtv, wfv, mux, mreq, mwr, mack;
  logic [IDX-1:0] eidx;

  always #5 clk = ~clk;

  wb_dcache_victim_ctrl #(
    .DCACHE_IDX_BITS (IDX),
    .CNT_WIDTH       (8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .lsummu2dcache_req_i  (req),
    .lsummu2dcache_wr_i   (wr),
    .dcache2lsummu_ack_o  (ack),
    .dcache_flush_i       (flush),
    .dcache_flush_ack_o   (fack),
    .cache_hit_i          (hit),
    .cache_evict_req_i    (evict),
    .dcache_valid_i       (valid),
    .victim_hit_i         (vhit),
    .cache_wr_o           (cwr),
    .cache_line_wr_o      (lwr),
    .cache_line_clean_o   (clean),
    .cache_wrb_req_o      (wrb),
    .evict_index_o        (eidx),
    .write_to_victim_o    (wtv),
    .write_from_victim_o  (wfv),
    .lsu_victim_mux_sel_o (mux),
    .dcache2mem_req_o     (mreq),
    .dcache2mem_wr_o      (mwr),
    .mem2dcache_ack_i     (mack)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o            (),
    .miss_cnt_o           (),
    .victim_hit_cnt_o     (),
    .wrback_cnt_o         ()
`endif
  );

  typedef struct packed {
    logic req, wr, flush, hit, evict, valid, vhit, mack;
  } stim_t;

  typedef struct packed {
    logic ack, fack, cwr, lwr, clean, wrb, wtv, wfv, mux, mreq, mwr;
    logic [IDX-1:0] idx;
  } expv_t;

  stim_t sq[$];
  expv_t eq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  int scen_cyc, first_ack, n_ack, n_cwr, n_wb_cyc, n_clean, n_wtv, n_lwr, n_fack, n_swap4;
  int wb_idx[$];

  task automatic push(input stim_t s, input expv_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push('0, '0);
  endtask

  // Cycle(s) where the line now hits: load acks at once, store writes next cycle.
  task automatic probe_hit(input logic w);
    stim_t s; expv_t e;
    s = '0; s.req = 1'b1; s.wr = w; s.hit = 1'b1;
    e = '0; e.ack = !w;
    push(s, e);
    if (w) begin
      s.hit = 1'b0;
      e = '0; e.cwr = 1'b1; e.ack = 1'b1;
      push(s, e);
    end
  endtask

  task automatic lsu_txn(input logic w, input logic h, input logic dirty,
                         input logic v, input logic vh, input int unsigned waits);
    stim_t s; expv_t e;
    s = '0; s.req = 1'b1; s.wr = w;
    e = '0;
    push(s, e);
    if (h) begin
      probe_hit(w);
    end else begin
      s.evict = dirty; s.valid = v; s.vhit = vh;
      push(s, e);
      s = '0; s.req = 1'b1; s.wr = w; s.valid = v;
      if (dirty) begin
        e = '0; e.mreq = 1'b1; e.mwr = 1'b1; e.wrb = 1'b1;
        for (int unsigned i = 0; i < waits; i++) push(s, e);
        s.mack = 1'b1; e.clean = 1'b1;
        push(s, e);
        s.mack = 1'b0;
      end
      if (vh) begin
        e = '0; e.wtv = v; e.wfv = 1'b1; e.mux = !w; e.ack = !w;
        push(s, e);
        if (w) probe_hit(w);
      end else begin
        e = '0; e.wtv = v;
        push(s, e);
        e = '0; e.mreq = 1'b1;
        for (int unsigned i = 0; i < waits; i++) push(s, e);
        s.mack = 1'b1; e.lwr = 1'b1;
        push(s, e);
        probe_hit(w);
      end
    end
  endtask

  task automatic flush_txn(input logic [3:0] mask, input int unsigned waits, input logic req_too);
    stim_t s; expv_t e;
    s = '0; s.flush = 1'b1; s.req = req_too;
    e = '0;
    push(s, e);
    for (int unsigned i = 0; i < 4; i++) begin
      e = '0; e.idx = IDX'(i);
      push(s, e);
      s.evict = mask[i];
      push(s, e);
      s.evict = 1'b0;
      if (mask[i]) begin
        e.mreq = 1'b1; e.mwr = 1'b1; e.wrb = 1'b1;
        for (int unsigned k = 0; k < waits; k++) push(s, e);
        s.mack = 1'b1; e.clean = 1'b1;
        push(s, e);
        s.mack = 1'b0;
      end
    end
    e = '0; e.fack = 1'b1; e.idx = IDX'(3);
    push(s, e);
  endtask

  task automatic drive(input stim_t s);
    req = s.req; wr = s.wr; flush = s.flush; hit = s.hit;
    evict = s.evict; valid = s.valid; vhit = s.vhit; mack = s.mack;
  endtask

  function automatic expv_t sample();
    expv_t g;
    g.ack = ack; g.fack = fack; g.cwr = cwr; g.lwr = lwr; g.clean = clean;
    g.wrb = wrb; g.wtv = wtv; g.wfv = wfv; g.mux = mux; g.mreq = mreq;
    g.mwr = mwr; g.idx = eidx;
    return g;
  endfunction

  task automatic compare(input string name, input expv_t e);
    expv_t g;
    g = sample();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b required %b", name, scen_cyc, g, e);
    end
    if (g.ack) begin n_ack++; if (first_ack < 0) first_ack = scen_cyc; end
    if (g.cwr) n_cwr++;
    if (g.mreq && g.mwr) n_wb_cyc++;
    if (g.mreq && g.mwr && mack) wb_idx.push_back(int'(g.idx));
    if (g.clean) n_clean++;
    if (g.wtv) n_wtv++;
    if (g.lwr) n_lwr++;
    if (g.fack) n_fack++;
    if (g.wtv && g.wfv && g.mux && g.ack) n_swap4++;
  endtask

  task automatic check_lit(input string name, input int got, input int req_v);
    checks++;
    if (got != req_v) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req_v);
    end
  endtask

  task automatic reset_stats();
    scen_cyc = 0; first_ack = -1; n_ack = 0; n_cwr = 0; n_wb_cyc = 0; n_clean = 0;
    n_wtv = 0; n_lwr = 0; n_fack = 0; n_swap4 = 0;
    wb_idx.delete();
  endtask

  task automatic run_queue(input string name);
    stim_t s; expv_t e;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      @(negedge clk);
      drive(s);
      #1;
      compare(name, e);
      scen_cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expv_t zero;
    zero = '0;
    reset_stats();
    drive('0);
    #1;
    compare("reset_state", zero);
    @(negedge clk);
    rst = 1'b0;

    reset_stats(); lsu_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0); idle(1); run_queue("load_hit");
    check_lit("load_hit_latency", first_ack, 1);
    check_lit("load_hit_no_cache_wr", n_cwr, 0);

    reset_stats(); lsu_txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0); idle(1); run_queue("store_hit");
    check_lit("store_hit_latency", first_ack, 2);
    check_lit("store_hit_cache_wr", n_cwr, 1);

    reset_stats(); lsu_txn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3); idle(1); run_queue("load_dirty_alloc");
    check_lit("wrback_cycles", n_wb_cyc, 4);
    check_lit("wrback_clean", n_clean, 1);
    check_lit("alloc_push", n_wtv, 1);
    check_lit("alloc_fill", n_lwr, 1);
    check_lit("alloc_ack", n_ack, 1);

    reset_stats(); lsu_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0); idle(1); run_queue("load_vswap");
    check_lit("vswap_all_high", n_swap4, 1);

    reset_stats(); lsu_txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0); idle(1); run_queue("store_dirty_vswap");
    check_lit("store_vswap_cache_wr", n_cwr, 1);

    reset_stats(); lsu_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1); idle(1); run_queue("store_alloc_invalid");
    check_lit("invalid_no_push", n_wtv, 0);

    reset_stats(); flush_txn(4'b1010, 2, 1'b0); idle(1); run_queue("flush");
    check_lit("flush_wb_count", wb_idx.size(), 2);
    check_lit("flush_wb_idx0", (wb_idx.size() > 0) ? wb_idx[0] : -1, 1);
    check_lit("flush_wb_idx1", (wb_idx.size() > 1) ? wb_idx[1] : -1, 3);
    check_lit("flush_ack_pulses", n_fack, 1);
    check_lit("flush_idx_cleared", int'(eidx), 0);

    reset_stats(); flush_txn(4'b0000, 0, 1'b1); lsu_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0); idle(1);
    run_queue("flush_wins");
    check_lit("flush_wins_ack", n_fack, 1);

    // Reset in the middle of a line read from memory.
    reset_stats();
    begin
      stim_t s; expv_t e;
      s = '0; s.req = 1'b1; e = '0;
      push(s, e);
      s.valid = 1'b1; push(s, e);
      e.wtv = 1'b1; push(s, e);
      e = '0; e.mreq = 1'b1; push(s, e);
    end
    run_queue("rst_prep");
    @(negedge clk);
    req = 1'b1; wr = 1'b0; valid = 1'b1; mack = 1'b0;
    #1;
    check_lit("rst_pre_mem_req", int'(mreq), 1);
    #2;
    rst = 1'b1;
    #1;
    compare("rst_async_outputs", zero);
    @(negedge clk);
    drive('0);
    rst = 1'b0;
    reset_stats(); lsu_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0); idle(1); run_queue("post_rst_load");
    check_lit("post_rst_latency", first_ack, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
